// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between CPU instruction fetch (IF)
//   and load/store (LS). At most one command per cycle, 1-cycle read return.
//   LS has fixed priority. After STARVE_LIMIT consecutive IF losses, IF is
//   forced to win the next contended cycle.
// Ports
//   clk, rst                       clock (rising), async active-high reset
//   if_req/if_addr                 fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata      fetch grant (comb), return at T+1
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata   load/store request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata      load/store grant (comb), load return at T+1
//   mem_en/we/be/addr/wdata        memory command (comb from the winner)
//   mem_rdata                      memory read data, 1 cycle after read cmd
//   if_stall_cnt                   saturating count of IF waiting cycles
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DW/8-1:0]   ls_be,
  input  logic [AW-1:0]     ls_addr,
  input  logic [DW-1:0]     ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DW-1:0]     ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [CNT_W-1:0]  if_stall_cnt
);

  localparam int BW = DW / 8;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Owner of the read data returning next cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  logic [1:0]       r_owner;
  logic [SW-1:0]    r_starve;
  logic [CNT_W-1:0] r_stall;

  logic w_force_if;
  logic w_if_win;

  // r_starve==STARVE_MAX is the FORCE_IF state; below it is NORMAL.
  // With STARVE_LIMIT=0 the counter is pinned at 0, so IF always wins.
  assign w_force_if = (r_starve == STARVE_MAX);
  assign w_if_win   = if_req & (~ls_req | w_force_if);

  // Grants are masked during reset so nothing reaches memory.
  assign if_gnt = ~rst & w_if_win;
  assign ls_gnt = ~rst & ls_req & ~w_if_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_we ? ls_be : {BW{1'b1}};
      mem_addr  = ls_addr;
      mem_wdata = ls_we ? ls_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_NONE;
      r_starve <= '0;
      r_stall  <= '0;
    end else begin
      // Stores produce no return, so they tag NONE like an idle cycle.
      if (if_gnt)               r_owner <= OWN_IF;
      else if (ls_gnt && !ls_we) r_owner <= OWN_LS;
      else                      r_owner <= OWN_NONE;

      if (!if_req || if_gnt)
        r_starve <= '0;
      else if (ls_gnt && r_starve != STARVE_MAX)
        r_starve <= r_starve + 1'b1;

      if (if_req && !if_gnt && r_stall != {CNT_W{1'b1}})
        r_stall <= r_stall + 1'b1;
    end
  end

  assign if_rvalid    = (r_owner == OWN_IF);
  assign ls_rvalid    = (r_owner == OWN_LS);
  assign if_rdata     = if_rvalid ? mem_rdata : '0;
  assign ls_rdata     = ls_rvalid ? mem_rdata : '0;
  assign if_stall_cnt = r_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] if_stall_cnt;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_stall_cnt(if_stall_cnt)
  );

  always #5 clk = ~clk;

  // Memory model driven only by the DUT's mem_* command.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  // Reference model: shadow memory written from the request fields, the IF
  // loss streak, the stall total and the expected next-cycle return.
  logic [31:0] rmem [256];
  int          streak, stall;
  int          exp_own;        // 0 none, 1 IF, 2 LS
  logic [31:0] exp_data;
  int          n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit lr, input bit lw, input logic [3:0] be,
                      input logic [31:0] la, input logic [31:0] wd);
    bit eg_if, eg_ls;
    logic [31:0] m;
    rst = r; if_req = ir; if_addr = ia;
    ls_req = lr; ls_we = lw; ls_be = be; ls_addr = la; ls_wdata = wd;
    #2;
    if (r) begin eg_if = 0; eg_ls = 0; exp_own = 0; stall = 0; streak = 0; end
    else if (ir && lr) begin eg_if = (streak == LIMIT); eg_ls = !eg_if; end
    else begin eg_if = ir; eg_ls = lr; end
    chk("if_gnt", if_gnt, eg_if);
    chk("ls_gnt", ls_gnt, eg_ls);
    chk("mem_en", mem_en, eg_if | eg_ls);
    chk("mem_we", mem_we, eg_ls & lw);
    chk("mem_be", mem_be, eg_if ? 4'hf : eg_ls ? (lw ? be : 4'hf) : 4'h0);
    chk("mem_addr", mem_addr, eg_if ? ia : eg_ls ? la : 32'h0);
    chk("mem_wdata", mem_wdata, (eg_ls && lw) ? wd : 32'h0);
    chk("if_rvalid", if_rvalid, exp_own == 1);
    chk("ls_rvalid", ls_rvalid, exp_own == 2);
    chk("if_rdata", if_rdata, (exp_own == 1) ? exp_data : 32'h0);
    chk("ls_rdata", ls_rdata, (exp_own == 2) ? exp_data : 32'h0);
    chk("if_stall_cnt", if_stall_cnt, stall);
    @(posedge clk); #1;
    if (r) begin
      exp_own = 0; stall = 0; streak = 0;
    end else begin
      if (ir && !eg_if && stall < 65535) stall++;
      if (!ir || eg_if) streak = 0;
      else if (streak < LIMIT) streak++;
      exp_own = 0;
      if (eg_if) begin exp_own = 1; exp_data = rmem[ia[9:2]]; end
      else if (eg_ls && !lw) begin exp_own = 2; exp_data = rmem[la[9:2]]; end
      else if (eg_ls && lw) begin
        m = rmem[la[9:2]];
        for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
        rmem[la[9:2]] = m;
      end
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; streak = 0; stall = 0; exp_own = 0; exp_data = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = i; rmem[i] = i; end
    #1;
    // Reset held with both requesting, then release: LS first.
    step(1, 1, 32'h20, 1, 0, 4'h0, 32'h40, 0);
    step(1, 1, 32'h20, 1, 0, 4'h0, 32'h40, 0);
    step(0, 1, 32'h20, 1, 0, 4'h0, 32'h40, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);   // clear counters
    // IF-only burst 0x0, 0x4, 0x8.
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Contention: LS x4, IF, repeating.
    for (int i = 0; i < 12; i++) step(0, 1, 32'h20, 1, 0, 4'h0, 32'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Partial store then load of the merged word.
    step(0, 0, 0, 1, 1, 4'b0011, 32'h30, 32'hAABBCCDD);
    step(0, 0, 0, 1, 0, 4'h0, 32'h30, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Load then reset pulse: its return must be dropped.
    step(0, 1, 32'h0, 1, 0, 4'h0, 32'h14, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // IF read then LS load back-to-back.
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 32'h8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), {22'h0, 8'($urandom), 2'b00},
           ($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom),
           {22'h0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
